// File: rtl/tabuleiro_ctl.sv
// tabuleiro_ctl: board controller for the 7x6 drop game.
// Takes a move request from the selection FSM and drops the piece into the
// lowest free row of the column. It then checks for a four-in-a-row or a full
// board, hands the placed piece to the VGA stage, and answers the selection
// FSM with a one-cycle response pulse.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   active              move request, held until answered
//   coluna_in/player_in requested column / mover (1 or 2)
//   response_ctl        pulse: 0 none, 1 rejected, 2 accepted
//   upd_*               placed-piece draw request to VGA, held until upd_ack
//   rd_row/rd_col       combinational board read address -> rd_cell
//   game_over/winner/draw  sticky game result
//   new_game            (only with NEW_GAME_EN) clears the board and result
//
// Build option: define NEW_GAME_EN to add the new_game input and the CLEAR state.
//
// State      | meaning
// IDLE       | wait for a request; latch column/player
// FIND       | scan the column bottom-up, one row per cycle
// PLACE      | write the cell, bump the move counter
// CHECK      | walk 4 directions, one cell per cycle, counting mover runs
// DRAW_UPD   | present upd_* to VGA until upd_ack
// ACC        | response 2 for one cycle
// REJ        | response 1 for one cycle
// RELEASE    | wait for active to drop
// CLEAR      | wipe one column per cycle (NEW_GAME_EN only)
module tabuleiro_ctl #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic [2:0] coluna_in,
  input  logic [1:0] player_in,
`ifdef NEW_GAME_EN
  input  logic       new_game,
`endif
  output logic [1:0] response_ctl,
  output logic       upd_valid,
  output logic [2:0] upd_row,
  output logic [2:0] upd_col,
  output logic [1:0] upd_player,
  input  logic       upd_ack,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw
);

  localparam int CELLS = ROWS * COLS;
  localparam int MW    = $clog2(CELLS + 1);
  localparam logic [MW-1:0]     MOVES_FULL = MW'(CELLS);
  localparam logic [3:0]        ROWS_U     = 4'(ROWS);
  localparam logic [3:0]        COLS_U     = 4'(COLS);
  localparam logic signed [4:0] ROWS_S     = $signed(5'(ROWS));
  localparam logic signed [4:0] COLS_S     = $signed(5'(COLS));
  localparam logic [2:0]        LAST_ROW   = 3'(ROWS - 1);
  localparam logic [2:0]        STEP_MAX   = 3'(WIN_LEN - 1);
  localparam logic [3:0]        RUN_WIN    = 4'(WIN_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FIND, S_PLACE, S_CHECK, S_DRAW_UPD, S_ACC, S_REJ, S_RELEASE, S_CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      board_q [ROWS][COLS];
  logic [1:0]      board_d [ROWS][COLS];
  logic [2:0]      row_q, row_d, col_q, col_d;
  logic [1:0]      player_q, player_d;
  logic [MW-1:0]   moves_q, moves_d;
  logic [1:0]      dir_q, dir_d;
  logic            neg_q, neg_d;
  logic [2:0]      step_q, step_d;
  logic [3:0]      run_q, run_d;
  logic            game_over_q, game_over_d;
  logic [1:0]      winner_q, winner_d;
  logic            draw_q, draw_d;
`ifdef NEW_GAME_EN
  logic [2:0]      clr_q, clr_d;
`endif

  // Cell under inspection during CHECK: centre + sign * step * direction.
  logic signed [4:0] k, dr, dc, tr, tc;
  logic              in_b, match;
  logic [3:0]        run_now;

  always_comb begin
    k  = $signed({2'b00, step_q});
    dr = '0;
    dc = '0;
    case (dir_q)
      2'd0:    dc = k;
      2'd1:    dr = k;
      2'd2:    begin dr = k; dc = k; end
      default: begin dr = k; dc = -k; end
    endcase
    if (neg_q) begin
      dr = -dr;
      dc = -dc;
    end
    tr    = $signed({2'b00, row_q}) + dr;
    tc    = $signed({2'b00, col_q}) + dc;
    in_b  = !tr[4] && (tr < ROWS_S) && !tc[4] && (tc < COLS_S);
    match = in_b && (board_q[tr[2:0]][tc[2:0]] == player_q);
    run_now = match ? run_q + 4'd1 : run_q;
  end

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    row_d       = row_q;
    col_d       = col_q;
    player_d    = player_q;
    moves_d     = moves_q;
    dir_d       = dir_q;
    neg_d       = neg_q;
    step_d      = step_q;
    run_d       = run_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    draw_d      = draw_q;
`ifdef NEW_GAME_EN
    clr_d       = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef NEW_GAME_EN
        if (new_game) begin
          clr_d   = 3'd0;
          state_d = S_CLEAR;
        end else
`endif
        if (active) begin
          col_d    = coluna_in;
          player_d = player_in;
          row_d    = 3'd0;
          if (game_over_q || ({1'b0, coluna_in} >= COLS_U) ||
              !(player_in == 2'd1 || player_in == 2'd2))
            state_d = S_REJ;
          else
            state_d = S_FIND;
        end
      end
      S_FIND: begin
        if (board_q[row_q][col_q] == 2'd0) state_d = S_PLACE;
        else if (row_q == LAST_ROW)        state_d = S_REJ;
        else                               row_d   = row_q + 3'd1;
      end
      S_PLACE: begin
        board_d[row_q][col_q] = player_q;
        if (moves_q != MOVES_FULL) moves_d = moves_q + MW'(1);
        run_d   = 4'd0;
        dir_d   = 2'd0;
        neg_d   = 1'b0;
        step_d  = 3'd1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Keep walking a side while it matches and is short of WIN_LEN-1 steps;
        // the run is only judged once both sides of a direction are done.
        if (match && step_q != STEP_MAX) begin
          run_d  = run_now;
          step_d = step_q + 3'd1;
        end else if (!neg_q) begin
          run_d  = run_now;
          neg_d  = 1'b1;
          step_d = 3'd1;
        end else if (run_now >= RUN_WIN) begin
          winner_d    = player_q;
          game_over_d = 1'b1;
          state_d     = S_DRAW_UPD;
        end else if (dir_q == 2'd3) begin
          if (moves_q == MOVES_FULL) begin
            draw_d      = 1'b1;
            game_over_d = 1'b1;
          end
          state_d = S_DRAW_UPD;
        end else begin
          dir_d  = dir_q + 2'd1;
          neg_d  = 1'b0;
          step_d = 3'd1;
          run_d  = 4'd0;
        end
      end
      S_DRAW_UPD: if (upd_ack) state_d = S_ACC;
      S_ACC:      state_d = S_RELEASE;
      S_REJ:      state_d = S_RELEASE;
      S_RELEASE: begin
`ifdef NEW_GAME_EN
        if (new_game) begin
          clr_d   = 3'd0;
          state_d = S_CLEAR;
        end else
`endif
        if (!active) state_d = S_IDLE;
      end
`ifdef NEW_GAME_EN
      S_CLEAR: begin
        for (int r = 0; r < ROWS; r++) board_d[r][clr_q] = 2'd0;
        if (clr_q == 3'(COLS - 1)) begin
          moves_d     = '0;
          game_over_d = 1'b0;
          winner_d    = 2'd0;
          draw_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          clr_d = clr_q + 3'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board_q[r][c] <= 2'd0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      player_q    <= 2'd0;
      moves_q     <= '0;
      dir_q       <= 2'd0;
      neg_q       <= 1'b0;
      step_q      <= 3'd0;
      run_q       <= 4'd0;
      game_over_q <= 1'b0;
      winner_q    <= 2'd0;
      draw_q      <= 1'b0;
`ifdef NEW_GAME_EN
      clr_q       <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      row_q       <= row_d;
      col_q       <= col_d;
      player_q    <= player_d;
      moves_q     <= moves_d;
      dir_q       <= dir_d;
      neg_q       <= neg_d;
      step_q      <= step_d;
      run_q       <= run_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      draw_q      <= draw_d;
`ifdef NEW_GAME_EN
      clr_q       <= clr_d;
`endif
    end
  end

  assign response_ctl = (state_q == S_ACC) ? 2'd2 : (state_q == S_REJ) ? 2'd1 : 2'd0;
  assign upd_valid    = (state_q == S_DRAW_UPD);
  assign upd_row      = row_q;
  assign upd_col      = col_q;
  assign upd_player   = player_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;
  assign draw         = draw_q;
  assign rd_cell      = (({1'b0, rd_row} < ROWS_U) && ({1'b0, rd_col} < COLS_U)) ?
                        board_q[rd_row][rd_col] : 2'd0;

endmodule

// File: tb/tb_tabuleiro_ctl.sv
// Directed bench for tabuleiro_ctl: drops, full column, horizontal and
// anti-diagonal wins, illegal requests and reset in the middle of a move.
module tb_tabuleiro_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       active = 1'b0;
  logic [2:0] coluna_in = 3'd0;
  logic [1:0] player_in = 2'd0;
  logic [1:0] response_ctl;
  logic       upd_valid;
  logic [2:0] upd_row, upd_col;
  logic [1:0] upd_player;
  logic       upd_ack = 1'b0;
  logic [2:0] rd_row = 3'd0, rd_col = 3'd0;
  logic [1:0] rd_cell;
  logic       game_over;
  logic [1:0] winner;
  logic       draw;
`ifdef NEW_GAME_EN
  logic       new_game = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  tabuleiro_ctl dut (
    .clk(clk), .reset(reset), .active(active), .coluna_in(coluna_in),
    .player_in(player_in),
`ifdef NEW_GAME_EN
    .new_game(new_game),
`endif
    .response_ctl(response_ctl), .upd_valid(upd_valid), .upd_row(upd_row),
    .upd_col(upd_col), .upd_player(upd_player), .upd_ack(upd_ack),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
    .game_over(game_over), .winner(winner), .draw(draw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic chk_cell(input string tag, input int r, input int c, input int exp);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
    chk(tag, 32'(rd_cell), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b0; active = 1'b0; upd_ack = 1'b0;
    repeat (2) sync();
    reset = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_resp"}, 32'(response_ctl), 0);
    chk({tag, "_uv"}, 32'(upd_valid), 0);
    chk({tag, "_urow"}, 32'(upd_row), 0);
    chk({tag, "_ucol"}, 32'(upd_col), 0);
    chk({tag, "_upl"}, 32'(upd_player), 0);
    chk({tag, "_go"}, 32'(game_over), 0);
    chk({tag, "_win"}, 32'(winner), 0);
    chk({tag, "_draw"}, 32'(draw), 0);
  endtask

  // One full request/response handshake. resp=-1 means no response arrived.
  task automatic do_move(input int col, input int pl, input int ack_dly,
                         output int resp, output int resp_nx, output int lat,
                         output int got, output int ur, output int uc,
                         output int up, output int vc);
    resp = 0; resp_nx = 0; lat = 0; got = 0; ur = 0; uc = 0; up = 0; vc = 0;
    active = 1'b1;
    coluna_in = 3'(col);
    player_in = 2'(pl);
    for (int c = 1; c <= 200 && resp == 0; c++) begin
      sync();
      if (upd_valid) begin
        if (got == 0) begin
          ur = int'(upd_row); uc = int'(upd_col); up = int'(upd_player);
        end
        got = 1;
        vc++;
        if (vc == ack_dly) upd_ack = 1'b1;
      end
      if (response_ctl != 2'd0) begin
        resp = int'(response_ctl);
        lat = c;
        upd_ack = 1'b0;
      end
    end
    if (resp == 0) resp = -1;
    upd_ack = 1'b0;
    sync();
    resp_nx = int'(response_ctl);
    active = 1'b0;
    sync();
  endtask

  int resp, resp_nx, lat, got, ur, uc, up, vc;
  int seen;

  initial begin
    // reset state
    do_reset();
    chk_idle_outputs("rst");
    chk_cell("rst_cell00", 0, 0, 0);
    sync();

    // T1: single drop, ack after 2 valid cycles
    do_move(3, 1, 2, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t1_resp", resp, 2);
    chk("t1_resp_pulse", resp_nx, 0);
    chk("t1_upd_seen", got, 1);
    chk("t1_upd_row", ur, 0);
    chk("t1_upd_col", uc, 3);
    chk("t1_upd_pl", up, 1);
    chk("t1_valid_cycles", vc, 2);
    chk_cell("t1_cell03", 0, 3, 1);
    chk("t1_go", 32'(game_over), 0);
    sync();

    // T2: fill column 0, then overflow it
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_move(0, (i % 2) + 1, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
      chk($sformatf("t2_fill%0d_resp", i), resp, 2);
      chk($sformatf("t2_fill%0d_row", i), ur, i);
    end
    do_move(0, 1, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t2_full_resp", resp, 1);
    chk("t2_full_lat", lat, 7);
    chk("t2_full_pulse", resp_nx, 0);
    chk("t2_full_noupd", got, 0);
    for (int i = 0; i < 6; i++)
      chk_cell($sformatf("t2_cell%0d0", i), i, 0, (i % 2) + 1);
    chk_cell("t2_cell_oob_row", 6, 0, 0);
    sync();
    chk("t2_go", 32'(game_over), 0);

    // T3: horizontal win for player 1 on row 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_move(i / 2, (i % 2) + 1, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
      chk($sformatf("t3_mv%0d_resp", i), resp, 2);
    end
    chk("t3_go_before", 32'(game_over), 0);
    do_move(3, 1, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t3_win_resp", resp, 2);
    chk("t3_win_row", ur, 0);
    chk("t3_win_col", uc, 3);
    chk("t3_go", 32'(game_over), 1);
    chk("t3_winner", 32'(winner), 1);
    chk("t3_draw", 32'(draw), 0);
    do_move(4, 2, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t3_after_resp", resp, 1);
    chk("t3_after_lat", lat, 1);
    chk("t3_after_noupd", got, 0);
    chk_cell("t3_after_cell04", 0, 4, 0);
    sync();
    chk("t3_winner_hold", 32'(winner), 1);

`ifdef NEW_GAME_EN
    new_game = 1'b1;
    sync();
    new_game = 1'b0;
    repeat (8) sync();
    chk("ng_go", 32'(game_over), 0);
    chk("ng_winner", 32'(winner), 0);
    chk_cell("ng_cell00", 0, 0, 0);
    chk_cell("ng_cell03", 0, 3, 0);
    chk_cell("ng_cell12", 1, 2, 0);
    sync();
    do_move(2, 2, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("ng_move_resp", resp, 2);
    chk("ng_move_row", ur, 0);
`endif

    // T4: anti-diagonal (+1,-1) win for player 2
    do_reset();
    begin
      int cols [10] = '{3, 2, 2, 1, 1, 1, 0, 0, 0, 0};
      int pls  [10] = '{2, 1, 2, 1, 1, 2, 1, 1, 1, 2};
      for (int i = 0; i < 9; i++) begin
        do_move(cols[i], pls[i], 1, resp, resp_nx, lat, got, ur, uc, up, vc);
        chk($sformatf("t4_mv%0d_resp", i), resp, 2);
      end
      chk("t4_go_before", 32'(game_over), 0);
      do_move(cols[9], pls[9], 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    end
    chk("t4_win_resp", resp, 2);
    chk("t4_win_row", ur, 3);
    chk("t4_win_col", uc, 0);
    chk("t4_go", 32'(game_over), 1);
    chk("t4_winner", 32'(winner), 2);

    // T5: illegal column / player
    do_reset();
    do_move(7, 1, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t5_col7_resp", resp, 1);
    chk("t5_col7_lat", lat, 1);
    chk("t5_col7_noupd", got, 0);
    do_move(2, 0, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t5_pl0_resp", resp, 1);
    chk("t5_pl0_lat", lat, 1);
    do_move(2, 3, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t5_pl3_resp", resp, 1);
    chk_cell("t5_cell02", 0, 2, 0);
    chk_cell("t5_cell_oob_col", 0, 7, 0);
    sync();
    do_move(2, 1, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t5_legal_resp", resp, 2);
    chk("t5_legal_row", ur, 0);
    chk("t5_legal_pl", up, 1);

    // T6a: reset while scanning the column
    do_reset();
    do_move(5, 1, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t6_pre_resp", resp, 2);
    active = 1'b1; coluna_in = 3'd5; player_in = 2'd2;
    sync();
    sync();
    reset = 1'b0; active = 1'b0;
    sync();
    chk_idle_outputs("t6a");
    chk_cell("t6a_cell05", 0, 5, 0);
    chk_cell("t6a_cell15", 1, 5, 0);
    reset = 1'b1;
    sync();

    // T6b: reset while waiting for upd_ack
    do_move(5, 1, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t6b_pre_resp", resp, 2);
    active = 1'b1; coluna_in = 3'd1; player_in = 2'd2;
    seen = 0;
    for (int c = 0; c < 60 && seen == 0; c++) begin
      sync();
      if (upd_valid) seen = 1;
    end
    chk("t6b_upd_seen", seen, 1);
    sync();
    chk("t6b_upd_held", 32'(upd_valid), 1);
    reset = 1'b0; active = 1'b0;
    sync();
    chk_idle_outputs("t6b");
    chk_cell("t6b_cell05", 0, 5, 0);
    chk_cell("t6b_cell01", 0, 1, 0);
    reset = 1'b1;
    sync();
    do_move(5, 2, 1, resp, resp_nx, lat, got, ur, uc, up, vc);
    chk("t6b_next_resp", resp, 2);
    chk("t6b_next_row", ur, 0);
    chk("t6b_next_pl", up, 2);
    chk_cell("t6b_next_cell", 0, 5, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tabuleiro_ctl.md
Name: tabuleiro_ctl

Overview:
Game-board controller for the 7-column, 6-row drop game. It sits directly downstream of the button/selection FSM and consumes its request: `active` high, with `coluna_in` and `player_in` holding the move. It keeps the board, drops the piece into the lowest free row, and checks for a four-in-a-row win or a draw. It then hands the placed piece to the VGA stage and answers the button FSM on `response_ctl`.

Parameters:
ROWS, 6, board rows (≤8); row 0 is the bottom.
COLS, 7, board columns (≤8).
WIN_LEN, 4, run length that wins.

Ports:
clk  in  1  clock.
reset  in  1  synchronous reset, active-low.
active  in  1  move request from the selection FSM; held high until a response is given.
coluna_in  in  3  requested column.
player_in  in  2  mover: 1 or 2.
response_ctl  out  2  one-cycle pulse. 0 = none, 1 = rejected, 2 = accepted (piece placed).
upd_valid  out  1  new-piece draw request to VGA.
upd_row  out  3  row of the placed piece.
upd_col  out  3  column of the placed piece.
upd_player  out  2  owner of the placed piece.
upd_ack  in  1  VGA has consumed the update.
rd_row  in  3  board read address, row.
rd_col  in  3  board read address, column.
rd_cell  out  2  combinational board read: 0 empty, 1 or 2 owner; 0 if the address is out of range.
game_over  out  1  game finished (win or draw).
winner  out  2  0 none, 1 or 2.
draw  out  1  board full with no winner.

Behaviour:
- Reset (reset=0 at a clk edge), takes effect even mid-operation:
  - all board cells 0, move counter 0, state IDLE;
  - all outputs 0.
- States and transitions:
  - IDLE: when active=1, latch coluna_in and player_in.
    - Go to REJ if game_over=1, coluna_in≥COLS, or player_in∉{1,2}.
    - Otherwise go to FIND with row index 0.
  - FIND: scan one row per cycle, starting at row 0.
    - First empty cell found: go to PLACE.
    - Row ROWS-1 checked and occupied (column full): go to REJ.
  - PLACE: write the cell, increment the move counter, clear the win-run counter, go to CHECK.
  - CHECK: evaluate directions (0,+1), (+1,0), (+1,+1), (+1,-1) in that order.
    - For each direction, walk the positive side, then the negative side, one cell per cycle, at most WIN_LEN-1 steps per side.
    - A side stops on an out-of-bounds cell or a cell not equal to the mover.
    - run = 1 + both side counts; run ≥ WIN_LEN means win.
    - On win: set winner=mover and game_over=1, skip the remaining directions, go to DRAW_UPD.
    - All directions done without a win: if move counter = ROWS*COLS, set draw=1 and game_over=1. Go to DRAW_UPD.
  - DRAW_UPD: hold upd_valid=1 with stable upd_row, upd_col, upd_player until upd_ack=1 is sampled. upd_valid drops the next cycle. Go to ACC.
  - ACC: response_ctl=2 for exactly one cycle, go to RELEASE.
  - REJ: response_ctl=1 for exactly one cycle, board untouched, no upd_valid, go to RELEASE.
  - RELEASE: wait for active=0, then go to IDLE. This prevents a held request from being processed twice.
- Once set, game_over, winner and draw hold until reset (or until a clear, see Optional Feature).
- All moves after game_over are rejected.
- Inputs coluna_in and player_in are ignored outside IDLE.
- The move counter is wide enough for ROWS*COLS and saturates there.
- Latency from the IDLE accept cycle to the response pulse:
  - rejection: 1 cycle, or ROWS+1 cycles for a full column;
  - acceptance: (row+1) + 1 + CHECK cycles + ack wait + 1.

Optional Feature:
NEW_GAME_EN.
- Defined:
  - adds input port new_game (1 bit);
  - new_game=1 in IDLE or RELEASE clears the board one column per cycle (COLS cycles);
  - then clears the move counter, game_over, winner and draw, and returns to IDLE;
  - active is ignored while clearing;
  - new_game is ignored in all other states.
- Undefined: no new_game port; only reset clears the board.

Test Plan:
1. Reset, then active=1, coluna_in=3, player_in=1 → FIND 1 cycle; upd_valid with row 0, col 3, player 1; bench acks after 2 cycles; response_ctl=2 for one cycle; rd_cell(0,3)=1.
2. Six accepted drops into col 0, then a 7th → response_ctl=1 one cycle after ROWS scan cycles; no upd_valid; the col 0 contents are unchanged.
3. p1 in cols 0,1,2 and p2 in cols 0,1,2 alternately, then p1 in col 3 → game_over=1, winner=1, response_ctl=2. The next request → response_ctl=1.
4. Build a (+1,-1) diagonal for p2 at (0,3), (1,2), (2,1), (3,0) → winner=2 after the last drop.
5. coluna_in=7 → response_ctl=1 one cycle after accept. player_in=0 → response_ctl=1. Board unchanged in both cases.
6. Assert reset during FIND and during DRAW_UPD with upd_ack withheld → next cycle all outputs 0, board empty, the next request is accepted normally. With NEW_GAME_EN, new_game after a win → board empty after 7 cycles and game_over=0.
